// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line plus received-word handshake and status of
// the parametrised UART receiver. The receiver side uses the master modport;
// the byte consumer (and the line driver) uses the slave modport.
interface uart_rx_param_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  rx_in;
   logic [DATA_WIDTH-1:0] rx_data_out;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  parity_err;
   logic                  frame_err;
   logic                  overrun_err;
   logic                  rx_busy;

   modport master (
      input  rx_in,
      input  rx_ready,
      output rx_data_out,
      output rx_valid,
      output parity_err,
      output frame_err,
      output overrun_err,
      output rx_busy
   );

   modport slave (
      output rx_in,
      output rx_ready,
      input  rx_data_out,
      input  rx_valid,
      input  parity_err,
      input  frame_err,
      input  overrun_err,
      input  rx_busy
   );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver (5..9 data bits, none/even/odd
// parity, 1 or 2 stop bits) with a 2-flop input synchroniser, 3-sample
// majority voting, false-start rejection and a valid/ready holding register.
// Optional feature: define UART_RX_BREAK_DETECT_EN to add the break_det output
// (an all-zero frame then pulses break_det instead of being delivered).
module uart_rx_param #(
   parameter int CLOCK_FREQ       = 75000000,
   parameter int BAUD_RATE        = 1156000,
   parameter int OVER_SAMPLE_RATE = 16,
   parameter int DATA_WIDTH       = 8,
   parameter int PARITY_MODE      = 0,
   parameter int STOP_BITS        = 1
) (
   input logic              r_clk,
   input logic              r_rst,
   uart_rx_param_if.master  bus
`ifdef UART_RX_BREAK_DETECT_EN
   ,
   output logic             break_det
`endif
);

   localparam int SR           = OVER_SAMPLE_RATE * BAUD_RATE;
   localparam int BAUD_DIV_RAW = (CLOCK_FREQ + SR / 2) / SR;
   localparam int BAUD_DIV     = (BAUD_DIV_RAW < 1) ? 1 : BAUD_DIV_RAW;
   localparam int BAUD_W       = $clog2(BAUD_DIV + 1);
   localparam int SAMP_W       = $clog2(OVER_SAMPLE_RATE);
   localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVER_SAMPLE_RATE - 1);
   localparam logic [SAMP_W-1:0] SAMP_A    = SAMP_W'(OVER_SAMPLE_RATE / 2 - 1);
   localparam logic [SAMP_W-1:0] SAMP_B    = SAMP_W'(OVER_SAMPLE_RATE / 2);
   localparam logic [SAMP_W-1:0] SAMP_C    = SAMP_W'(OVER_SAMPLE_RATE / 2 + 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic              ODD_PAR   = (PARITY_MODE == 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
`ifdef UART_RX_BREAK_DETECT_EN
      ,
      BRK_WAIT
`endif
   } state_t;

   state_t                state_q, state_d;
   logic                  rx_meta_q, rx_meta_d;
   logic                  rx_s_q, rx_s_d;
   logic                  rx_prev_q, rx_prev_d;
   logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [SAMP_W-1:0]     samp_cnt_q, samp_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  s0_q, s0_d;
   logic                  s1_q, s1_d;
   logic                  perr_q, perr_d;
   logic                  ferr_q, ferr_d;
   logic                  zero_q, zero_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  valid_q, valid_d;
   logic                  perr_out_q, perr_out_d;
   logic                  ferr_out_q, ferr_out_d;
   logic                  ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
   logic                  brk_q, brk_d;
`endif

   logic tick;
   logic dec_tick;
   logic bit_end;
   logic maj;
   logic frame_done;
   logic frame_brk;

   // Oversampling strobes: decision on the third voting sample, bit ends at wrap.
   assign tick     = (state_q != IDLE) && (baud_cnt_q == BAUD_LAST);
   assign dec_tick = tick && (samp_cnt_q == SAMP_C);
   assign bit_end  = tick && (samp_cnt_q == SAMP_LAST);
   assign maj      = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);

   // Synchroniser chain, plus one extra stage to spot the 1->0 start edge.
   always_comb begin
      rx_meta_d = bus.rx_in;
      rx_s_d    = rx_meta_q;
      rx_prev_d = rx_s_q;
   end

   // Baud and sample counters: parked at zero in IDLE so a start edge restarts them.
   always_comb begin
      baud_cnt_d = baud_cnt_q;
      samp_cnt_d = samp_cnt_q;
      s0_d       = s0_q;
      s1_d       = s1_q;
      if (state_q == IDLE) begin
         baud_cnt_d = '0;
         samp_cnt_d = '0;
      end else if (tick) begin
         baud_cnt_d = '0;
         samp_cnt_d = (samp_cnt_q == SAMP_LAST) ? '0 : samp_cnt_q + 1'b1;
      end else begin
         baud_cnt_d = baud_cnt_q + 1'b1;
      end
      if (tick && (samp_cnt_q == SAMP_A)) s0_d = rx_s_q;
      if (tick && (samp_cnt_q == SAMP_B)) s1_d = rx_s_q;
   end

   // Frame FSM: next state, data shifting and per-frame error tracking.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      zero_d     = zero_q;
      frame_done = 1'b0;
      frame_brk  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
               state_d   = START;
               bit_cnt_d = '0;
               perr_d    = 1'b0;
               ferr_d    = 1'b0;
               zero_d    = 1'b1;
            end
         end
         START: begin
            if (dec_tick && maj) begin
               state_d = IDLE;
            end else if (bit_end) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (dec_tick) begin
               shift_d = {maj, shift_q[DATA_WIDTH-1:1]};
               if (maj) zero_d = 1'b0;
            end
            if (bit_end) begin
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (dec_tick) begin
               perr_d = (maj != ((^shift_q) ^ ODD_PAR));
               if (maj) zero_d = 1'b0;
            end
            if (bit_end) begin
               state_d   = STOP;
               bit_cnt_d = '0;
            end
         end
         STOP: begin
            // The frame completes at the last stop bit's decision, leaving
            // half a bit of margin to catch the next start edge.
            if (dec_tick) begin
               if (!maj) ferr_d = 1'b1;
               if (maj) zero_d = 1'b0;
               if (bit_cnt_q == STOP_LAST) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
`ifdef UART_RX_BREAK_DETECT_EN
                  if (zero_q && !maj) begin
                     frame_brk = 1'b1;
                     state_d   = BRK_WAIT;
                  end
`endif
               end
            end
            if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
         end
`ifdef UART_RX_BREAK_DETECT_EN
         BRK_WAIT: begin
            if (rx_s_q) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Holding register: load a completed frame if the slot is free or being
   // drained this cycle, otherwise drop it and flag the overrun.
   always_comb begin
      data_out_d = data_out_q;
      valid_d    = valid_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      ovr_d      = 1'b0;
      if (valid_q && bus.rx_ready) valid_d = 1'b0;
      if (frame_done && !frame_brk) begin
         if (!valid_q || bus.rx_ready) begin
            data_out_d = shift_q;
            perr_out_d = perr_q;
            ferr_out_d = ferr_q | ~maj;
            valid_d    = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      brk_d = frame_brk;
`endif
   end

   // State register; the synchroniser presets to the idle line level.
   always_ff @(posedge r_clk or posedge r_rst) begin
      if (r_rst) begin
         state_q    <= IDLE;
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         baud_cnt_q <= '0;
         samp_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         s0_q       <= 1'b1;
         s1_q       <= 1'b1;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         zero_q     <= 1'b0;
         data_out_q <= '0;
         valid_q    <= 1'b0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         brk_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rx_s_q     <= rx_s_d;
         rx_prev_q  <= rx_prev_d;
         baud_cnt_q <= baud_cnt_d;
         samp_cnt_q <= samp_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         s0_q       <= s0_d;
         s1_q       <= s1_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         zero_q     <= zero_d;
         data_out_q <= data_out_d;
         valid_q    <= valid_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         ovr_q      <= ovr_d;
`ifdef UART_RX_BREAK_DETECT_EN
         brk_q      <= brk_d;
`endif
      end
   end

   assign bus.rx_data_out = data_out_q;
   assign bus.rx_valid    = valid_q;
   assign bus.parity_err  = perr_out_q;
   assign bus.frame_err   = ferr_out_q;
   assign bus.overrun_err = ovr_q;
   assign bus.rx_busy     = (state_q != IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
   assign break_det       = brk_q;
`endif

endmodule
